// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and stage-bus layout for the 5-stage pipeline
package cpu_pkg;

  // First instruction fetched after reset
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  // IF -> ID bus: {pc[31:0], inst[31:0]}
  localparam int FS_TO_DS_BUS_W  = 64;
  localparam int FS_BUS_PC_MSB   = 63;
  localparam int FS_BUS_PC_LSB   = 32;
  localparam int FS_BUS_INST_MSB = 31;
  localparam int FS_BUS_INST_LSB = 0;

  // ID -> IF redirect bus: {br_taken, br_target[31:0]}
  localparam int BR_BUS_W        = 33;
  localparam int BR_BUS_TAKEN    = 32;
  localparam int BR_BUS_TGT_MSB  = 31;
  localparam int BR_BUS_TGT_LSB  = 0;

  // Sequential fetch successor; 32-bit wrap, carry out dropped
  function automatic logic [31:0] pc_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, pre-IF address issue, ID handshake, redirects
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter int          FS_TO_DS_W = FS_TO_DS_BUS_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ds_allowin,
  input  logic                  br_taken,
  input  logic [31:0]           br_target,
  output logic                  fs_to_ds_valid,
  output logic [FS_TO_DS_W-1:0] fs_to_ds_bus,
  output logic                  inst_sram_we,
  output logic [31:0]           inst_sram_addr,
  output logic [31:0]           inst_sram_wdata,
  input  logic [31:0]           inst_sram_rdata
);

  // Single-cycle SRAM: data for the held PC is always ready
  localparam logic FS_READY_GO = 1'b1;

  logic [31:0] fs_pc;
  logic        fs_valid;
  logic        to_fs_go;
  logic        br_pend;
  logic [31:0] br_pend_tgt;

  logic        to_fs_valid;
  logic        fs_allowin;
  logic [31:0] nextpc;

  // Pre-IF only starts issuing one edge after reset is released
  assign to_fs_valid = to_fs_go;

  assign fs_allowin = ~fs_valid | (FS_READY_GO & ds_allowin);

  // A live redirect kills whatever IF holds this cycle so ID never sees it
  assign fs_to_ds_valid = fs_valid & FS_READY_GO & ~br_taken;
  assign fs_to_ds_bus   = {fs_pc, inst_sram_rdata};

  // Live redirect beats a redirect parked during a stall
  assign nextpc = br_taken ? br_target   :
                  br_pend  ? br_pend_tgt :
                             pc_seq(fs_pc);

  // While stalled, re-read the held PC so rdata still matches fs_pc next cycle
  assign inst_sram_addr  = fs_allowin ? nextpc : fs_pc;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'h0;

  // Out-of-reset flag: releases pre-IF one edge after resetn deasserts
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_fs_go <= 1'b0;
    end else begin
      to_fs_go <= 1'b1;
    end
  end

  // Fetch PC / valid advance; a redirect during a stall is parked in br_pend
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_pc       <= RESET_PC - 32'd4;
      fs_valid    <= 1'b0;
      br_pend     <= 1'b0;
      br_pend_tgt <= 32'h0;
    end else if (fs_allowin) begin
      fs_valid <= to_fs_valid;
      if (to_fs_valid) begin
        fs_pc   <= nextpc;
        br_pend <= 1'b0;
      end
    end else if (br_taken) begin
      fs_valid    <= 1'b0;
      br_pend     <= 1'b1;
      br_pend_tgt <= br_target;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed table-driven bench for if_stage
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  if_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction content is a fixed scramble of its address
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_c3c3;
  endfunction

  // Synchronous instruction memory: data for last cycle's address
  always @(posedge clk) inst_sram_rdata <= inst_of(inst_sram_addr);

  typedef struct {
    logic        da;
    logic        bt;
    logic [31:0] tgt;
    logic        exp_valid;
    logic        chk_bus;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic add(input logic da, input logic bt, input logic [31:0] tgt,
                     input logic ev, input logic cb, input logic [31:0] pc,
                     input logic [31:0] addr);
    vec_t v;
    v.da = da; v.bt = bt; v.tgt = tgt; v.exp_valid = ev;
    v.chk_bus = cb; v.exp_pc = pc; v.exp_addr = addr;
    vecs.push_back(v);
  endtask

  // Drive one row just after a falling edge, check, then wait for the next falling edge
  task automatic apply(input int idx);
    vec_t v;
    string tag;
    v = vecs[idx];
    ds_allowin = v.da;
    br_taken   = v.bt;
    br_target  = v.tgt;
    #1;
    tag = $sformatf("row%0d", idx);
    chk({tag, ".valid"}, {31'h0, fs_to_ds_valid}, {31'h0, v.exp_valid});
    chk({tag, ".addr"}, inst_sram_addr, v.exp_addr);
    if (v.chk_bus) begin
      chk({tag, ".pc"}, fs_to_ds_bus[63:32], v.exp_pc);
      chk({tag, ".inst"}, fs_to_ds_bus[31:0], inst_of(v.exp_pc));
    end
    @(negedge clk);
  endtask

  initial begin
    // reset release and straight-line fetch
    add(1, 0, 0,            0, 0, 0,            32'h1c00_0000);
    add(1, 0, 0,            0, 0, 0,            32'h1c00_0000);
    add(1, 0, 0,            1, 1, 32'h1c00_0000, 32'h1c00_0004);
    add(1, 0, 0,            1, 1, 32'h1c00_0004, 32'h1c00_0008);
    // ID stall for three cycles
    add(0, 0, 0,            1, 1, 32'h1c00_0008, 32'h1c00_0008);
    add(0, 0, 0,            1, 1, 32'h1c00_0008, 32'h1c00_0008);
    add(0, 0, 0,            1, 1, 32'h1c00_0008, 32'h1c00_0008);
    add(1, 0, 0,            1, 1, 32'h1c00_0008, 32'h1c00_000c);
    add(1, 0, 0,            1, 1, 32'h1c00_000c, 32'h1c00_0010);
    // redirect while flowing
    add(1, 1, 32'h1c00_0100, 0, 1, 32'h1c00_0010, 32'h1c00_0100);
    add(1, 0, 0,            1, 1, 32'h1c00_0100, 32'h1c00_0104);
    // redirect while stalled -> parked, then issued
    add(0, 1, 32'h1c00_0200, 0, 1, 32'h1c00_0104, 32'h1c00_0104);
    add(0, 0, 0,            0, 0, 0,            32'h1c00_0200);
    add(1, 0, 0,            1, 1, 32'h1c00_0200, 32'h1c00_0204);
    add(1, 0, 0,            1, 1, 32'h1c00_0204, 32'h1c00_0208);
    // back-to-back redirects
    add(1, 1, 32'h1c00_0300, 0, 1, 32'h1c00_0208, 32'h1c00_0300);
    add(1, 1, 32'h1c00_0400, 0, 1, 32'h1c00_0300, 32'h1c00_0400);
    add(1, 0, 0,            1, 1, 32'h1c00_0400, 32'h1c00_0404);
    add(1, 0, 0,            1, 1, 32'h1c00_0404, 32'h1c00_0408);
    // parked redirect overridden by a live one
    add(0, 1, 32'h1c00_0500, 0, 1, 32'h1c00_0408, 32'h1c00_0408);
    add(1, 1, 32'h1c00_0600, 0, 0, 0,            32'h1c00_0600);
    add(1, 0, 0,            1, 1, 32'h1c00_0600, 32'h1c00_0604);
    // misaligned target fetched as given
    add(1, 1, 32'h1c00_0702, 0, 1, 32'h1c00_0604, 32'h1c00_0702);
    add(1, 0, 0,            1, 1, 32'h1c00_0702, 32'h1c00_0706);
    add(1, 0, 0,            1, 1, 32'h1c00_0706, 32'h1c00_070a);
    // PC wrap at top of address space
    add(1, 1, 32'hffff_fffc, 0, 1, 32'h1c00_070a, 32'hffff_fffc);
    add(1, 0, 0,            1, 1, 32'hffff_fffc, 32'h0000_0000);
    add(1, 0, 0,            1, 1, 32'h0000_0000, 32'h0000_0004);

    resetn     = 1'b0;
    ds_allowin = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.valid", {31'h0, fs_to_ds_valid}, 32'h0);
    chk("reset.addr", inst_sram_addr, RST_PC);
    chk("reset.we", {31'h0, inst_sram_we}, 32'h0);
    chk("reset.wdata", inst_sram_wdata, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(i);

    // asynchronous reset in the middle of a valid cycle
    ds_allowin = 1'b1;
    br_taken   = 1'b0;
    #1;
    chk("mid.pre_valid", {31'h0, fs_to_ds_valid}, 32'h1);
    chk("mid.pre_pc", fs_to_ds_bus[63:32], 32'h0000_0004);
    #1 resetn = 1'b0;
    #1;
    chk("mid.valid", {31'h0, fs_to_ds_valid}, 32'h0);
    chk("mid.addr", inst_sram_addr, RST_PC);
    repeat (2) @(negedge clk);
    #1;
    chk("mid.hold_valid", {31'h0, fs_to_ds_valid}, 32'h0);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) apply(i);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
